// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory arbiter.
// Holds the arbiter state enum, the load/store width codes (funct3),
// the packed memory request payload and the misalignment helper.
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  // Load widths
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  // Store widths
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int unsigned XLEN = 32;

  // Payload presented to memory for one access
  typedef struct packed {
    logic            write;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes never fault.
  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lsb);
    return ((func3[1:0] == F3_LH[1:0]) && addr_lsb[0]) ||
           ((func3[1:0] == F3_LW[1:0]) && (addr_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one
// single-outstanding memory port.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   ifReq/ifAddress         - fetch request (held until ifReady)
//   ifReady/ifData          - fetch completion pulse and word
//   dReq/dWrite/dFunc3/dAddress/dDataOut - data request (held until dReady)
//   dReady/dDataIn/dError   - data completion pulse, load data, misalign flag
//   memValid/memWrite/memFunc3/memAddress/memDataOut - memory request
//   memDataIn/memAck        - memory response
// Configuration:
//   MEM_ARB_RR_EN defined   - round-robin between fetch and data on conflict
//   MEM_ARB_RR_EN undefined - data priority, fetch forced after MAX_WAIT data grants
module mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddress,
  output logic        ifReady,
  output logic [31:0] ifData,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [2:0]  dFunc3,
  input  logic [31:0] dAddress,
  input  logic [31:0] dDataOut,
  output logic        dReady,
  output logic [31:0] dDataIn,
  output logic        dError,
  output logic        memValid,
  output logic        memWrite,
  output logic [2:0]  memFunc3,
  output logic [31:0] memAddress,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn,
  input  logic        memAck
);

  arb_state_e  state_q, state_d;
  mem_req_t    mem_q, mem_d;
  logic        mem_valid_q, mem_valid_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  // High when, in IDLE, data is the requester that wins this cycle
  logic        pick_data;
  logic        any_req;

  // Fetches are always word aligned, so the low address bits are dropped
  logic        unused_if_lsbs;
  assign unused_if_lsbs = ^ifAddress[1:0];

  assign any_req = ifReq | dReq;

`ifdef MEM_ARB_RR_EN
  localparam int unsigned UNUSED_MAX_WAIT = MAX_WAIT;

  // Remembers whether the last grant went to data; reset favours data next
  logic last_data_q, last_data_d;

  assign pick_data = dReq & ~(ifReq & last_data_q);

  always_comb begin
    last_data_d = last_data_q;
    if ((state_q == IDLE) && any_req) last_data_d = pick_data;
  end

  always_ff @(posedge clock) begin
    if (reset) last_data_q <= 1'b0;
    else       last_data_q <= last_data_d;
  end
`else
  localparam int unsigned WAIT_W     = 4;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  // Consecutive data grants taken while a fetch was waiting
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign pick_data = dReq & ~(ifReq & (wait_q >= WAIT_LIMIT));

  always_comb begin
    wait_d = wait_q;
    if ((state_q == IDLE) && ifReq) begin
      if (!pick_data)                wait_d = '0;
      else if (wait_q < WAIT_LIMIT)  wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`endif

  // Next-state and registered output logic
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    mem_valid_d = mem_valid_q;
    if_ready_d  = 1'b0;
    if_data_d   = if_data_q;
    d_ready_d   = 1'b0;
    d_data_d    = d_data_q;
    d_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_data) begin
          if (misaligned(dFunc3, dAddress[1:0])) begin
            // Rejected locally; memory never sees the access
            d_ready_d = 1'b1;
            d_error_d = 1'b1;
          end else begin
            mem_d       = '{write: dWrite, func3: dFunc3, addr: dAddress, wdata: dDataOut};
            mem_valid_d = 1'b1;
            state_d     = DATA;
          end
        end else if (ifReq) begin
          mem_d       = '{write: 1'b0, func3: F3_LW, addr: {ifAddress[31:2], 2'b00}, wdata: 32'h0};
          mem_valid_d = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH, DATA: begin
        if (memAck) begin
          mem_valid_d = 1'b0;
          state_d     = IDLE;
          // A requester that has gone away gets no pulse
          if (state_q == FETCH) begin
            if_ready_d = ifReq;
            if_data_d  = memDataIn;
          end else begin
            d_ready_d  = dReq;
            d_data_d   = memDataIn;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_q       <= '0;
      mem_valid_q <= 1'b0;
      if_ready_q  <= 1'b0;
      if_data_q   <= '0;
      d_ready_q   <= 1'b0;
      d_data_q    <= '0;
      d_error_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      mem_valid_q <= mem_valid_d;
      if_ready_q  <= if_ready_d;
      if_data_q   <= if_data_d;
      d_ready_q   <= d_ready_d;
      d_data_q    <= d_data_d;
      d_error_q   <= d_error_d;
    end
  end

  assign ifReady    = if_ready_q;
  assign ifData     = if_data_q;
  assign dReady     = d_ready_q;
  assign dDataIn    = d_data_q;
  assign dError     = d_error_q;
  assign memValid   = mem_valid_q;
  assign memWrite   = mem_q.write;
  assign memFunc3   = mem_q.func3;
  assign memAddress = mem_q.addr;
  assign memDataOut = mem_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, a memory responder, a
// transaction-level reference model and a per-cycle compare process.
module tb_mem_arbiter;
  import rv32i_pkg::*;

  localparam int TB_MAX_WAIT = 2;

  logic        clock;
  logic        reset;
  logic        ifReq;
  logic [31:0] ifAddress;
  logic        ifReady;
  logic [31:0] ifData;
  logic        dReq;
  logic        dWrite;
  logic [2:0]  dFunc3;
  logic [31:0] dAddress;
  logic [31:0] dDataOut;
  logic        dReady;
  logic [31:0] dDataIn;
  logic        dError;
  logic        memValid;
  logic        memWrite;
  logic [2:0]  memFunc3;
  logic [31:0] memAddress;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;
  logic        memAck;

  mem_arbiter #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .ifReq(ifReq), .ifAddress(ifAddress), .ifReady(ifReady), .ifData(ifData),
    .dReq(dReq), .dWrite(dWrite), .dFunc3(dFunc3), .dAddress(dAddress),
    .dDataOut(dDataOut), .dReady(dReady), .dDataIn(dDataIn), .dError(dError),
    .memValid(memValid), .memWrite(memWrite), .memFunc3(memFunc3),
    .memAddress(memAddress), .memDataOut(memDataOut),
    .memDataIn(memDataIn), .memAck(memAck)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay extra memValid cycles
  int          ack_delay = 0;
  int          rsp_cnt   = 0;
  logic [31:0] rsp_data  = 32'h0;
  bit          force_ack = 1'b0;

  initial begin
    memAck    = 1'b0;
    memDataIn = 32'h0;
  end

  always @(posedge clock) begin
    #2;
    if (force_ack) begin
      memAck    = 1'b1;
      memDataIn = 32'hFFFF_0000;
    end else if (memValid) begin
      if (rsp_cnt == ack_delay) begin
        memAck    = 1'b1;
        memDataIn = rsp_data;
        rsp_cnt   = 0;
      end else begin
        memAck  = 1'b0;
        rsp_cnt = rsp_cnt + 1;
      end
    end else begin
      memAck  = 1'b0;
      rsp_cnt = 0;
    end
  end

  // Reference model: one access in flight at most, tracked as "who owns memory"
  bit          m_on = 1'b0;
  int          m_owner = 0;        // 0 none, 1 fetch, 2 data
  int          m_wait = 0;
  bit          m_last_data = 1'b0;
  logic        m_memValid, m_memWrite, m_ifReady, m_dReady, m_dError;
  logic [2:0]  m_memFunc3;
  logic [31:0] m_memAddress, m_memDataOut, m_ifData, m_dDataIn;

  always @(posedge clock) begin
    bit take_d;
    bit bad;
    if (reset) begin
      m_on = 1'b1; m_owner = 0; m_wait = 0; m_last_data = 1'b0;
      m_memValid = 1'b0; m_ifReady = 1'b0; m_dReady = 1'b0; m_dError = 1'b0;
    end else begin
      m_ifReady = 1'b0; m_dReady = 1'b0; m_dError = 1'b0;
      if (m_owner != 0) begin
        if (memAck) begin
          if (m_owner == 1 && ifReq) begin m_ifReady = 1'b1; m_ifData = memDataIn; end
          if (m_owner == 2 && dReq)  begin m_dReady  = 1'b1; m_dDataIn = memDataIn; end
          m_owner = 0;
          m_memValid = 1'b0;
        end
      end else if (ifReq || dReq) begin
`ifdef MEM_ARB_RR_EN
        take_d = dReq && !(ifReq && m_last_data);
        m_last_data = take_d;
`else
        take_d = dReq && !(ifReq && m_wait >= TB_MAX_WAIT);
        if (!take_d) m_wait = 0;
        else if (ifReq && m_wait < TB_MAX_WAIT) m_wait = m_wait + 1;
`endif
        if (take_d) begin
          bad = (dFunc3[1:0] == 2'd1 && dAddress[0]) ||
                (dFunc3[1:0] == 2'd2 && dAddress[1:0] != 2'd0);
          if (bad) begin
            m_dReady = 1'b1; m_dError = 1'b1;
          end else begin
            m_owner = 2; m_memValid = 1'b1; m_memWrite = dWrite;
            m_memFunc3 = dFunc3; m_memAddress = dAddress; m_memDataOut = dDataOut;
          end
        end else begin
          m_owner = 1; m_memValid = 1'b1; m_memWrite = 1'b0;
          m_memFunc3 = 3'd2; m_memAddress = ifAddress & 32'hFFFF_FFFC; m_memDataOut = 32'h0;
        end
      end
    end
  end

  // Per-cycle compare and activity counters
  int mv_cnt  = 0;
  int rdy_cnt = 0;

  always @(negedge clock) begin
    if (m_on) begin
      chk1("memValid", memValid, m_memValid);
      if (m_memValid) begin
        chk1("memWrite", memWrite, m_memWrite);
        chk32("memFunc3", 32'(memFunc3), 32'(m_memFunc3));
        chk32("memAddress", memAddress, m_memAddress);
        if (m_memWrite) chk32("memDataOut", memDataOut, m_memDataOut);
      end
      chk1("ifReady", ifReady, m_ifReady);
      chk1("dReady", dReady, m_dReady);
      chk1("dError", dError, m_dError);
      if (m_ifReady) chk32("ifData", ifData, m_ifData);
      if (m_dReady && !m_dError && !dWrite) chk32("dDataIn", dDataIn, m_dDataIn);
    end
    if (memValid) mv_cnt = mv_cnt + 1;
    if (ifReady || dReady) rdy_cnt = rdy_cnt + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] a, input logic [31:0] rsp,
                          input int dly, input logic [31:0] exp_addr, input int exp_lat,
                          input int exp_mv);
    int n;
    int mv0;
    bit seen;
    ack_delay = dly; rsp_data = rsp; ifAddress = a; ifReq = 1'b1;
    mv0 = mv_cnt; seen = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (i == 1) chk32({nm, "_addr"}, memAddress, exp_addr);
      if (ifReady) begin seen = 1'b1; n = i; end
    end
    ifReq = 1'b0;
    chk32({nm, "_latency"}, 32'(n), 32'(exp_lat));
    if (seen) chk32({nm, "_data"}, ifData, rsp);
    tick();
    chk32({nm, "_memvalid_cycles"}, 32'(mv_cnt - mv0), 32'(exp_mv));
  endtask

  task automatic do_data(input string nm, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                         input int dly, input int exp_lat, input logic exp_err, input int exp_mv);
    int n;
    int mv0;
    bit seen;
    ack_delay = dly; rsp_data = rsp;
    dWrite = wr; dFunc3 = f3; dAddress = a; dDataOut = wd; dReq = 1'b1;
    mv0 = mv_cnt; seen = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (i == 1) begin
        if (exp_err) chk1({nm, "_no_mem"}, memValid, 1'b0);
        else begin
          chk32({nm, "_addr"}, memAddress, a);
          chk1({nm, "_write"}, memWrite, wr);
        end
      end
      if (dReady) begin
        seen = 1'b1; n = i;
        chk1({nm, "_error"}, dError, exp_err);
        if (!wr && !exp_err) chk32({nm, "_data"}, dDataIn, rsp);
      end
    end
    dReq = 1'b0;
    chk32({nm, "_latency"}, 32'(n), 32'(exp_lat));
    tick();
    chk32({nm, "_memvalid_cycles"}, 32'(mv_cnt - mv0), 32'(exp_mv));
  endtask

  task automatic run_conflict(input string nm, input string exp);
    string order;
    order = "";
    ack_delay = 0; rsp_data = 32'h0BAD_F00D;
    ifAddress = 32'h0000_0400;
    dWrite = 1'b0; dFunc3 = F3_LW; dAddress = 32'h0000_0800; dDataOut = 32'h0;
    ifReq = 1'b1; dReq = 1'b1;
    for (int i = 0; i < 100 && order.len() < 6; i++) begin
      tick();
      if (ifReady) order = {order, "F"};
      if (dReady)  order = {order, "D"};
    end
    ifReq = 1'b0; dReq = 1'b0;
    chk_str(nm, order, exp);
    repeat (3) tick();
  endtask

  string exp_order;

  initial begin
    int mv0;
    int r0;
`ifdef MEM_ARB_RR_EN
    exp_order = "DFDFDF";
`else
    exp_order = "DDFDDF";
`endif
    reset = 1'b1; ifReq = 1'b0; ifAddress = 32'h0; dReq = 1'b0; dWrite = 1'b0;
    dFunc3 = 3'd0; dAddress = 32'h0; dDataOut = 32'h0;

    // Reset values
    tick(); tick();
    chk1("rst_memValid", memValid, 1'b0);
    chk1("rst_memWrite", memWrite, 1'b0);
    chk1("rst_ifReady", ifReady, 1'b0);
    chk1("rst_dReady", dReady, 1'b0);
    chk1("rst_dError", dError, 1'b0);
    chk32("rst_memAddress", memAddress, 32'h0);
    chk32("rst_ifData", ifData, 32'h0);
    reset = 1'b0;
    tick();

    // Single fetch and aligned data accesses
    do_fetch("fetch102", 32'h0000_0102, 32'h0000_0013, 0, 32'h0000_0100, 2, 1);
    do_data("lw200", 1'b0, F3_LW, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0, 1);
    do_data("sb203", 1'b1, F3_SB, 32'h0000_0203, 32'h0000_0055, 32'h0, 0, 2, 1'b0, 1);
    do_data("lh202", 1'b0, F3_LH, 32'h0000_0202, 32'h0, 32'h1234_ABCD, 0, 2, 1'b0, 1);
    do_data("sh20a", 1'b1, F3_SH, 32'h0000_020A, 32'h0000_BEEF, 32'h0, 0, 2, 1'b0, 1);

    // Misaligned: no memory cycle, immediate error completion
    do_data("lw013", 1'b0, F3_LW, 32'h0000_0013, 32'h0, 32'h0, 0, 1, 1'b1, 0);
    do_data("lhu201", 1'b0, F3_LHU, 32'h0000_0201, 32'h0, 32'h0, 0, 1, 1'b1, 0);
    do_data("sw206", 1'b1, F3_SW, 32'h0000_0206, 32'h1, 32'h0, 0, 1, 1'b1, 0);
    do_data("lbu207", 1'b0, F3_LBU, 32'h0000_0207, 32'h0, 32'h0000_00A7, 0, 2, 1'b0, 1);

    // Stalled memory: six memValid cycles, one ready
    r0 = rdy_cnt;
    do_fetch("fetch_stall", 32'h0000_03FF, 32'hCAFE_0001, 5, 32'h0000_03FC, 7, 6);
    do_data("lw_stall", 1'b0, F3_LW, 32'h0000_0300, 32'h0, 32'h5A5A_A5A5, 5, 7, 1'b0, 6);
    chk32("stall_ready_count", 32'(rdy_cnt - r0), 32'd2);

    // Fetch requester leaves before completion: silent finish
    ack_delay = 3; ifAddress = 32'h0000_0500; ifReq = 1'b1;
    r0 = rdy_cnt; mv0 = mv_cnt;
    tick(); tick();
    ifReq = 1'b0;
    repeat (8) tick();
    chk32("drop_ready_count", 32'(rdy_cnt - r0), 32'd0);
    chk32("drop_memvalid_cycles", 32'(mv_cnt - mv0), 32'd4);

    // Conflict ordering
    run_conflict("conflict_order", exp_order);

    // Reset in the middle of an access, ack arriving afterwards
    ack_delay = 20;
    dWrite = 1'b0; dFunc3 = F3_LW; dAddress = 32'h0000_0800; ifAddress = 32'h0000_0400;
    ifReq = 1'b1; dReq = 1'b1;
    tick(); tick();
    chk1("midrst_busy", memValid, 1'b1);
    reset = 1'b1; ifReq = 1'b0; dReq = 1'b0;
    tick();
    reset = 1'b0; force_ack = 1'b1;
    chk1("midrst_memValid", memValid, 1'b0);
    chk1("midrst_memWrite", memWrite, 1'b0);
    chk1("midrst_ifReady", ifReady, 1'b0);
    chk1("midrst_dReady", dReady, 1'b0);
    chk1("midrst_dError", dError, 1'b0);
    chk32("midrst_memAddress", memAddress, 32'h0);
    chk32("midrst_memFunc3", 32'(memFunc3), 32'h0);
    chk32("midrst_memDataOut", memDataOut, 32'h0);
    chk32("midrst_ifData", ifData, 32'h0);
    chk32("midrst_dDataIn", dDataIn, 32'h0);
    r0 = rdy_cnt; mv0 = mv_cnt;
    tick();
    force_ack = 1'b0;
    repeat (4) tick();
    chk32("midrst_ready_count", 32'(rdy_cnt - r0), 32'd0);
    chk32("midrst_memvalid_cycles", 32'(mv_cnt - mv0), 32'd0);

    // Arbitration history must be cleared by that reset
    run_conflict("post_reset_order", exp_order);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning the maximum consecutive data grants while a fetch is pending (range 1-15).
REQ-002 SHALL have ports (clock, reset first), each as name, direction, width, meaning:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ifReq  in  1  fetch request; held with ifAddress until ifReady.
- ifAddress  in  32  fetch byte address.
- ifReady  out  1  one-cycle pulse; fetch complete.
- ifData  out  32  fetched word; valid while ifReady=1.
- dReq  in  1  data request; held with all d* inputs until dReady.
- dWrite  in  1  1=store, 0=load.
- dFunc3  in  3  RISC-V load/store width code.
- dAddress  in  32  data byte address.
- dDataOut  in  32  store data.
- dReady  out  1  one-cycle pulse; data access complete.
- dDataIn  out  32  load data; valid while dReady=1 and dWrite=0.
- dError  out  1  misaligned access; valid with dReady.
- memValid  out  1  memory request; held until memAck.
- memWrite  out  1  memory write strobe qualifier.
- memFunc3  out  3  access width to memory.
- memAddress  out  32  memory byte address.
- memDataOut  out  32  memory write data.
- memDataIn  in  32  memory read data; sampled on memAck.
- memAck  in  1  memory completion; ignored unless memValid=1.

Function
REQ-003 SHALL use states IDLE, FETCH, DATA; at most one memory access outstanding.
REQ-004 SHALL, in IDLE, choose a requester from ifReq/dReq per REQ-008/REQ-009 and drive registered memValid=1 and mem* fields from the next cycle.
REQ-005 SHALL hold all mem* outputs stable while memValid=1 and memAck=0.
REQ-006 SHALL, on memAck=1: deassert memValid next cycle; pulse the granted ready for exactly one cycle next cycle with registered read data; return to IDLE next cycle.
REQ-007 SHALL have a minimum latency of 2 cycles from request to ready with memAck in the first memValid cycle; a new grant may issue in the ready cycle (memValid again the following cycle).
REQ-008 SHALL give data priority over fetch when both request in IDLE, except that a fetch SHALL win once waitCount reaches MAX_WAIT.
REQ-009 SHALL increment a 4-bit waitCount on each data grant while ifReq=1, clear it on each fetch grant, and saturate at MAX_WAIT.
REQ-010 SHALL drive fetch accesses as memAddress={ifAddress[31:2],2'b00}, memFunc3=2, memWrite=0.
REQ-011 SHALL pass data accesses unchanged: dAddress, dFunc3, dWrite, dDataOut.
REQ-012 SHALL treat a halfword access (dFunc3[1:0]=1) with dAddress[0]=1, or a word access (dFunc3[1:0]=2) with dAddress[1:0]!=0, as misaligned: no memory access is issued, and dReady=1 with dError=1 on the next cycle.
REQ-013 SHALL keep dError=0 on every non-error completion.
REQ-014 SHALL ignore memAck while in IDLE.
REQ-015 SHALL give no ready when a requester drops its request before ready; the in-flight access completes silently.

Reset
REQ-016 SHALL, with reset=1 at a clock edge, enter IDLE and clear waitCount; memValid, memWrite, ifReady, dReady and dError SHALL be 0, and all data/address outputs 0 by the next cycle.
REQ-017 SHALL, on reset mid-access, abandon the access; a later memAck SHALL be ignored.

Configuration
REQ-018 SHALL, when MEM_ARB_RR_EN is defined, replace REQ-008/REQ-009 with round-robin: on conflict, grant the requester not granted last; the last-granted flag resets to fetch (data wins the first conflict).
REQ-019 SHALL, when MEM_ARB_RR_EN is undefined, use fixed data priority with waitCount starvation limit.

Structure
REQ-020 SHALL place the state enum and the F3 load/store width constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2) in shared package rv32i_pkg.
REQ-021 SHALL be a single module with no sub-modules.

Verification
REQ-022 SHALL cover a single fetch: ifReq=1, ifAddress=0x102, memAck on the first memValid cycle, memDataIn=0x00000013 -> memAddress=0x100, ifReady in cycle 2, ifData=0x13.
REQ-023 SHALL cover a conflict with MAX_WAIT=2 and ifReq/dReq continuously high -> grant order D,D,F,D,D,F; with MEM_ARB_RR_EN -> D,F,D,F.
REQ-024 SHALL cover a misaligned access: dReq=1, dFunc3=2, dAddress=0x13 -> memValid stays 0, dReady=1 and dError=1 one cycle later.
REQ-025 SHALL cover a stalled memory: memAck delayed 5 cycles -> mem* fields stable for all 6 memValid cycles, ready exactly once.
REQ-026 SHALL cover reset mid-access: reset while memValid=1, memAck the cycle after -> no ready pulse, state IDLE, waitCount=0.
